// File: rtl/barrido_selector.sv
// barrido_selector: scans the enabled mask channels onto a 2-to-4 decoder select with a fixed dwell; BARRIDO_BLANKING_EN adds a blank cycle between channels
module barrido_selector #(
  parameter int PRESC_W   = 16,
  parameter int PRESC_MAX = 49999
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic [3:0] mask,
  output logic       en,
  output logic [1:0] sel,
  output logic       tick,
  output logic       idle
);
`ifdef BARRIDO_BLANKING_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam logic [1:0] IDLE = 2'd0, SCAN = 2'd1, BLANK = 2'd2;
  localparam logic [PRESC_W-1:0] TERM = PRESC_W'(PRESC_MAX);
  logic [1:0] state_q, state_d, sel_q, sel_d, tgt, low;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic en_q, en_d, tick_q, tick_d, idle_q, idle_d, go, term;
  assign go = run && |mask;
  assign term = presc_q == TERM;
  always_comb begin
    tgt = sel_q;
    low = 2'd0;
    for (int i = 3; i >= 1; i--) if (mask[sel_q + 2'(i)]) tgt = sel_q + 2'(i);
    for (int i = 3; i >= 0; i--) if (mask[i]) low = 2'(i);
  end
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = '0;
    en_d    = 1'b0;
    tick_d  = 1'b0;
    idle_d  = 1'b0;
    if (state_q == IDLE) begin
      state_d = go ? SCAN : IDLE;
      sel_d   = go ? low : sel_q;
      en_d    = go;
      idle_d  = !go;
    end else if (!go) begin
      state_d = IDLE;
      idle_d  = 1'b1;
    end else if (state_q == BLANK || (term && !BLANK_EN)) begin
      state_d = SCAN;
      sel_d   = tgt;
      tick_d  = 1'b1;
      en_d    = mask[tgt];
    end else if (term) begin
      state_d = BLANK;
    end else begin
      presc_d = presc_q + 1'b1;
      en_d    = mask[sel_q];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      sel_q   <= 2'd0;
      en_q    <= 1'b0;
      tick_q  <= 1'b0;
      idle_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      sel_q   <= sel_d;
      en_q    <= en_d;
      tick_q  <= tick_d;
      idle_q  <= idle_d;
    end
  end
  assign en   = en_q;
  assign sel  = sel_q;
  assign tick = tick_q;
  assign idle = idle_q;
endmodule

// File: tb/tb_barrido_selector.sv
// tb_barrido_selector: directed and random scan stimulus checked against a dwell-period model of the selector
module tb_barrido_selector;
  localparam int DWELL = 4;
`ifdef BARRIDO_BLANKING_EN
  localparam int PERIOD = DWELL + 1;
`else
  localparam int PERIOD = DWELL;
`endif
  logic clk = 1'b0, rst = 1'b1, run = 1'b0;
  logic [3:0] mask = 4'h0;
  logic en, tick, idle, prev_tick;
  logic [1:0] sel;
  int cmp_n = 0, err_n = 0;
  int m_active = 0, m_ch = 0, m_ph = 0, m_en = 0, m_tick = 0, m_idle = 1;
  barrido_selector #(.PRESC_W(4), .PRESC_MAX(DWELL - 1)) dut (
    .clk(clk), .rst(rst), .run(run), .mask(mask),
    .en(en), .sel(sel), .tick(tick), .idle(idle)
  );
  always #5 clk = ~clk;
  function automatic int lowest(input logic [3:0] m);
    for (int k = 0; k < 4; k++) if (m[k]) return k;
    return 0;
  endfunction
  function automatic int next_ch(input int c, input logic [3:0] m);
    for (int k = 1; k < 4; k++) if (m[(c + k) % 4]) return (c + k) % 4;
    return c;
  endfunction
  task automatic chk(input string tag, input int got, input int exp);
    cmp_n++;
    assert (got === exp) else begin
      err_n++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
      $error("%s got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic model;
    m_tick = 0;
    if (rst) begin
      m_active = 0; m_ch = 0; m_ph = 0; m_en = 0; m_idle = 1;
    end else if (!m_active) begin
      if (run && mask != 0) begin
        m_active = 1; m_ch = lowest(mask); m_ph = 0; m_en = 1; m_idle = 0;
      end else begin
        m_en = 0; m_idle = 1;
      end
    end else if (!run || mask == 0) begin
      m_active = 0; m_ph = 0; m_en = 0; m_idle = 1;
    end else begin
      m_ph = (m_ph + 1) % PERIOD;
      if (m_ph == 0) begin
        m_ch = next_ch(m_ch, mask);
        m_tick = 1;
      end
      m_en = (m_ph < DWELL) ? int'(mask[m_ch]) : 0;
    end
  endtask
  task automatic step(input logic r, input logic ru, input logic [3:0] m);
    rst = r; run = ru; mask = m;
    prev_tick = tick;
    @(posedge clk);
    model();
    #1;
    chk("en", int'(en), m_en);
    chk("sel", int'(sel), m_ch);
    chk("tick", int'(tick), m_tick);
    chk("idle", int'(idle), m_idle);
    chk("tick_twice", int'(tick && prev_tick), 0);
  endtask
  initial begin
    step(1, 0, 4'h0);
    step(1, 0, 4'h0);
    chk("reset_idle", int'(idle), 1);
    for (int i = 0; i < 20; i++) step(0, 1, 4'hF);
    step(1, 1, 4'hF);
    for (int i = 0; i < 4; i++) step(0, 1, 4'hF);
    step(0, 0, 4'hF);
    for (int i = 0; i < 18; i++) step(0, 1, 4'hA);
    for (int i = 0; i < 13; i++) step(0, 1, 4'h4);
    step(0, 1, 4'h0);
    step(0, 1, 4'h0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'h3);
    step(0, 0, 4'h3);
    step(0, 0, 4'h3);
    for (int i = 0; i < 12; i++) step(0, 1, 4'h3);
    for (int i = 0; i < 6; i++) step(0, 1, (i == 2) ? 4'h2 : 4'h3);
    for (int i = 0; i < 500; i++) begin
      logic [3:0] m;
      m = ($urandom_range(0, 9) == 0) ? 4'($urandom) : mask;
      step($urandom_range(0, 99) == 0, $urandom_range(0, 19) != 0, m);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule

// File: doc/barrido_selector.md
BARRIDO_SELECTOR -- requirements
Module: barrido_selector

Interface
REQ-001 SHALL have parameter PRESC_W, default 16: prescaler counter width in bits.
REQ-002 SHALL have parameter PRESC_MAX, default 49999: prescaler terminal count, dwell = PRESC_MAX+1 cycles per channel; must fit in PRESC_W bits.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset; one clock, reset synchronous and active-high.
REQ-005 SHALL have port run  input  1  scan request, level-sensitive.
REQ-006 SHALL have port mask  input  4  channel enable, bit i enables channel i.
REQ-007 SHALL have port en  output  1  decoder enable, feeds downstream 2-to-4 decoder en.
REQ-008 SHALL have port sel  output  2  decoder select, feeds downstream 2-to-4 decoder sel.
REQ-009 SHALL have port tick  output  1  one-cycle pulse on every channel advance.
REQ-010 SHALL have port idle  output  1  high while FSM in IDLE.

Function
REQ-011 SHALL implement FSM states IDLE, SCAN, plus BLANK when BLANKING_EN defined; all outputs registered.
REQ-012 IDLE: en=0, tick=0, idle=1, prescaler held at 0, sel holds last value.
REQ-013 IDLE -> SCAN when run=1 and mask!=0 sampled at an edge; same edge loads sel = lowest set bit of mask, en=1, idle=0 (1-cycle latency).
REQ-014 IDLE with run=1 and mask=0: remain IDLE.
REQ-015 SCAN: prescaler increments each cycle 0..PRESC_MAX; at PRESC_MAX it wraps to 0 on the next edge.
REQ-016 Advance target = next set bit of mask strictly after current sel, searching upward, wrapping 3->0; if only current channel set, target = current sel.
REQ-017 SCAN with en output gated: en=1 only while mask[sel]=1; a channel masked mid-dwell drives en=0 from the next edge until the next advance.
REQ-018 run=0 or mask=0 sampled in SCAN or BLANK: next edge -> IDLE, en=0, tick=0, prescaler cleared, sel held; overrides a coincident terminal count.
REQ-019 run and mask changes SHALL only take effect at clock edges; no combinational path from inputs to outputs.
REQ-020 tick SHALL never be high for two consecutive cycles and SHALL be 0 in IDLE.

Reset
REQ-021 rst=1 at an edge: state=IDLE, prescaler=0, sel=2'b00, en=0, tick=0, idle=1.
REQ-022 rst SHALL take priority over run, mask and all state transitions, including mid-dwell and during BLANK.
REQ-023 After rst released with run=1 and mask!=0 held, first en=1 SHALL appear on the first edge with rst=0.

Configuration
REQ-024 Macro BARRIDO_BLANKING_EN SHALL control inter-channel blanking.
REQ-025 Without BARRIDO_BLANKING_EN: at terminal count, same edge loads sel=target, pulses tick, en stays 1 if mask[target]=1; period per channel = PRESC_MAX+1 cycles.
REQ-026 With BARRIDO_BLANKING_EN: at terminal count, next edge enters BLANK with en=0, sel held; following edge loads sel=target, tick=1, en=1, returns to SCAN; period per channel = PRESC_MAX+2 cycles.
REQ-027 With BARRIDO_BLANKING_EN and single enabled channel, BLANK cycle SHALL still be inserted.

Verification (PRESC_MAX=3 for all scenarios)
REQ-028 rst=1 two cycles, run=0 -> en=0, sel=00, tick=0, idle=1; rst=1 during SCAN -> same values next edge.
REQ-029 mask=4'b1111, run=1 held, no macro -> sel sequence 00,01,10,11,00 each 4 cycles, en=1 continuously, tick=1 on each change.
REQ-030 mask=4'b1010, run=1 -> first sel=01, then 11, 01, ...; channels 00 and 10 never selected.
REQ-031 mask=4'b0100 -> sel=10 constant, en=1, tick pulse every 4 cycles; mask=4'b0000 -> IDLE, en=0 next edge.
REQ-032 run dropped at prescaler=3 -> next edge en=0, idle=1, tick=0, sel held; run reasserted -> restart at lowest mask bit, prescaler from 0.
REQ-033 BARRIDO_BLANKING_EN defined, mask=4'b0011 -> en pattern 1,1,1,1,0 repeating, sel toggles 00/01 on the cycle after the en=0 cycle, tick coincident with sel change.
